// File: rtl/down_counter_timer.sv
// Loadable down counter / countdown timer with one-shot and auto-reload modes.
// Flags terminal count with a registered one-cycle pulse on the 1 -> 0 step.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             mode,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc_pulse,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPIRED
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload_reg, reload_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc_pulse   <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      tc_pulse   <= tc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    tc_nxt     = 1'b0;
    if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      state_nxt  = (load_val != '0) ? RUN : IDLE;
    end else if (stop) begin
      state_nxt = IDLE;
    end else if (state == RUN && en) begin
      if (count > ONE) begin
        count_nxt = count - ONE;
      end else if (count == ONE) begin
        count_nxt = '0;
        tc_nxt    = 1'b1;
        state_nxt = mode ? RUN : EXPIRED;
      end else if (mode) begin
        count_nxt = reload_reg;
      end else begin
        // mode dropped while parked at zero: expire without reload or pulse
        state_nxt = EXPIRED;
      end
    end
  end

  assign zero = (count == '0);
  assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// Randomized and directed bench for down_counter_timer.
// A behavioural model predicts count, zero, tc_pulse and busy each cycle.
module tb_down_counter_timer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         mode;
  logic         stop;
  logic [W-1:0] count;
  logic         zero;
  logic         tc_pulse;
  logic         busy;

  int errors = 0;
  int checks = 0;

  int mc;
  int mr;
  bit mrun;
  bit mtc;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_val(load_val),
    .en(en),
    .mode(mode),
    .stop(stop),
    .count(count),
    .zero(zero),
    .tc_pulse(tc_pulse),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Plain-arithmetic reference: running flag plus an integer count.
  task automatic model_edge();
    int old;
    if (!rst) begin
      mc = 0; mr = 0; mrun = 0; mtc = 0;
    end else if (load) begin
      mc = int'(load_val); mr = mc;
      mrun = (mc != 0); mtc = 0;
    end else if (stop) begin
      mrun = 0; mtc = 0;
    end else if (mrun && en) begin
      old = mc;
      mtc = (old == 1);
      if (old > 0) mc = old - 1;
      else if (mode) mc = mr;
      if (old <= 1 && !mode) mrun = 0;
    end else begin
      mtc = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("m_count", 32'(count), 32'(mc));
    check("m_zero", 32'(zero), 32'(mc == 0));
    check("m_tc", 32'(tc_pulse), 32'(mtc));
    check("m_busy", 32'(busy), 32'(mrun));
  endtask

  initial begin
    rst = 1'b0; load = 1'b1; load_val = 4'd9;
    en = 1'b1; mode = 1'b0; stop = 1'b0;
    mc = 0; mr = 0; mrun = 0; mtc = 0;

    step(); step();
    check("rst_count", 32'(count), 0);
    check("rst_zero", 32'(zero), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_tc", 32'(tc_pulse), 0);

    // one-shot from 5
    rst = 1'b1; load = 1'b1; load_val = 4'd5; mode = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      load = 1'b0;
      check("os_count", 32'(count), 32'(5 - i));
      check("os_tc", 32'(tc_pulse), 32'(i == 5));
    end
    for (int i = 0; i < 10; i++) begin
      step();
      check("os_hold", 32'(count), 0);
      check("os_busy", 32'(busy), 0);
      check("os_tc0", 32'(tc_pulse), 0);
    end

    // auto-reload from 3
    load = 1'b1; load_val = 4'd3; mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      load = 1'b0;
      check("ar_count", 32'(count), 32'(3 - (i % 4)));
      check("ar_tc", 32'(tc_pulse), 32'(i % 4 == 3));
      check("ar_busy", 32'(busy), 1);
    end

    // enable gating then stop
    load = 1'b1; load_val = 4'd4; mode = 1'b0; en = 1'b1;
    step();
    load = 1'b0;
    check("gate_load", 32'(count), 4);
    en = 1'b1; step(); check("gate_1", 32'(count), 3);
    en = 1'b0; step(); check("gate_2", 32'(count), 3);
    en = 1'b0; step(); check("gate_3", 32'(count), 3);
    en = 1'b1; step(); check("gate_4", 32'(count), 2);
    stop = 1'b1; step();
    stop = 1'b0;
    check("stop_busy", 32'(busy), 0);
    check("stop_count", 32'(count), 2);
    check("stop_tc", 32'(tc_pulse), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stop_hold", 32'(count), 2);
    end

    // load of zero
    load = 1'b1; load_val = 4'd0; step();
    load = 1'b0;
    check("l0_busy", 32'(busy), 0);
    check("l0_zero", 32'(zero), 1);
    check("l0_tc", 32'(tc_pulse), 0);

    // load 15 colliding with the 1 -> 0 step
    load = 1'b1; load_val = 4'd2; en = 1'b1; mode = 1'b0; step();
    load = 1'b0; step();
    check("pre_one", 32'(count), 1);
    load = 1'b1; load_val = 4'd15; step();
    load = 1'b0;
    check("l15_count", 32'(count), 15);
    check("l15_tc", 32'(tc_pulse), 0);
    check("l15_busy", 32'(busy), 1);

    // reset mid-count
    load = 1'b1; load_val = 4'd8; step();
    load = 1'b0; step();
    check("pre_rst", 32'(count), 7);
    rst = 1'b0; step();
    rst = 1'b1;
    check("mid_rst", 32'(count), 0);
    check("mid_rst_busy", 32'(busy), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 99) != 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom_range(0, (1 << W) - 1));
      en       = ($urandom_range(0, 3) != 0);
      mode     = ($urandom_range(0, 4) != 0);
      stop     = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
